alu_exec_unit: RTL
==================

# alu_exec_unit

Registered execute-stage ALU for the MIPS datapath, successor to the combinational ALU decoder. Decodes `aluop`/`funct` into a 4-bit ALU control internally and executes the full integer R-type set: arithmetic, logic, set-less-than, shifts, plus iterative multiply/divide into HI/LO. Single-cycle ops complete in one clock. Mult/div stall the issuing side through a ready/valid handshake.

## Interface
- `WIDTH`, 32, datapath width; power of two, ≥8. Derived localparam `SHW = $clog2(WIDTH)`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_in` in 1: operation presented.
- `ready_in` out 1: unit can accept; high when idle.
- `aluop` in 2: 00 add, 01 sub, 10 decode `funct`, 11 or (ori).
- `funct` in 6: MIPS funct field.
- `shamt` in 5: shift amount for sll/srl/sra; only low SHW bits used.
- `a` in WIDTH: rs operand.
- `b` in WIDTH: rt operand or immediate.
- `valid_out` out 1: one-cycle pulse, result valid.
- `result` out WIDTH: registered result.
- `zero` out 1: `result == 0`, registered with `result`.
- `overflow` out 1: signed overflow of add/sub, registered.
- `illegal` out 1: unrecognised funct, registered.

## Operation
- Handshake: an op is accepted on an edge where `valid_in && ready_in`. `valid_in` while `ready_in` low is ignored; the issuer holds it.
- aluop=10 funct set:
  - add/addu 100000/100001, sub/subu 100010/100011.
  - and 100100, or 100101, xor 100110, nor 100111.
  - slt 101010 (signed), sltu 101011 (unsigned); result is 1 or 0, zero-extended.
  - sll/srl/sra 000000/000010/000011 shift `b` by `shamt[SHW-1:0]`.
  - sllv/srlv/srav 000100/000110/000111 shift `b` by `a[SHW-1:0]`.
  - mfhi 010000 and mflo 010010 return HI / LO.
  - mult/multu 011000/011001 and div/divu 011010/011011 are multi-cycle.
- Overflow:
  - Flagged only for add 100000, sub 100010, aluop 00 and aluop 01.
  - The result still holds the wrapped sum.
  - addu/subu never flag.
- Unknown funct: result 0, `illegal`=1; HI/LO unchanged.
- Mult: HI:LO = 2·WIDTH-bit product.
- Div: LO = quotient, HI = remainder.
  - Truncating division; the remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = `a`; no exception.
- Mult/div completion: `valid_out` pulses with `result` = new LO, `zero`/`overflow`/`illegal` = 0.
- Muldiv FSM: IDLE → BUSY on acceptance of mult/div.
  - BUSY runs WIDTH iterations: shift-add multiply or restoring divide on operand magnitudes.
  - BUSY → FIXUP after the last iteration; FIXUP applies the signs and writes HI/LO.
  - FIXUP → IDLE.

## Timing
- Reset values:
  - `ready_in`=1 once reset is released.
  - `valid_out`, `result`, `zero`, `overflow`, `illegal` = 0.
  - HI = LO = 0; FSM in IDLE.
- Single-cycle op accepted at edge E0: `valid_out`=1 and outputs valid after E0 for exactly one cycle. Back-to-back acceptance every cycle.
- Mult/div accepted at E0:
  - `ready_in`=0 after E0.
  - BUSY covers edges E1..E(WIDTH); FIXUP at E(WIDTH+1).
  - After E(WIDTH+1): HI/LO are updated, `valid_out`=1, `ready_in`=1.
  - Latency is WIDTH+1 cycles.
- An op may be accepted in the cycle `valid_out` is high. mfhi issued then sees the new HI.
- `result`, `zero`, `overflow` and `illegal` hold their last value when `valid_out`=0.
- Reset asserted mid-muldiv aborts immediately: FSM IDLE, HI/LO=0, no `valid_out`.

## Configuration
- `ALU_MULDIV_EN` defined: multiply/divide datapath, FSM and HI/LO are compiled in as above.
- Undefined:
  - mult/multu/div/divu/mfhi/mflo decode as illegal.
  - `ready_in` is tied to 1; every op is single-cycle.
  - No HI/LO registers exist.

## Structure
- Package `alu_pkg`:
  - funct localparams.
  - 4-bit `alu_ctrl_t` encoding (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MFHI, MFLO, MUL, DIV, ILL).
  - aluop constants.
- Top module: combinational decode → control, single-cycle ALU, output registers.
- Sub-module `muldiv_iter`:
  - FSM, counter, shift registers, sign fixup.
  - Instantiated only under `ALU_MULDIV_EN`.

## Test plan
- Reset:
  - Pulse `rst_n` low mid-div (WIDTH=32, cycle 10) → `ready_in`=1 after release, HI=LO=0, no `valid_out` pulse.
  - Then mflo → result 0.
- Back-to-back:
  - aluop=10 add a=0x7FFFFFFF b=1 → result 0x80000000, `overflow`=1.
  - Next cycle addu same operands → `overflow`=0.
  - slt a=0xFFFFFFFF b=1 → 1; sltu → 0.
- Shifts: sra b=0x80000000 shamt=4 → 0xF8000000; srlv a=36 b=0xF0 → 0x0F (amount 4).
- Mult: a=-3 b=7 → `ready_in` low for 33 cycles, then `valid_out`; mfhi → 0xFFFFFFFF, mflo → 0xFFFFFFEB.
- Div: a=-7 b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=5 b=0 → LO=0xFFFFFFFF, HI=5.
- Illegal and config check:
  - funct=111111 → result 0, `illegal`=1.
  - With `ALU_MULDIV_EN` undefined, mult → `illegal`=1, `ready_in` stays 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: funct codes, aluop codes,
// the 4-bit ALU control encoding, the decoded-op payload and the decoder.
package alu_pkg;

  // aluop encodings from the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  // MIPS R-type funct codes
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // Internal 4-bit ALU control
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_MFHI = 4'd11,
    ALU_MFLO = 4'd12,
    ALU_MUL  = 4'd13,
    ALU_DIV  = 4'd14,
    ALU_ILL  = 4'd15
  } alu_ctrl_t;

  // Multiply/divide sequencer states
  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_BUSY  = 2'd1,
    MD_FIXUP = 2'd2
  } md_state_t;

  // Decoded operation: control plus qualifiers
  typedef struct packed {
    alu_ctrl_t ctrl;
    logic      ovf_en;  // signed overflow is reported
    logic      var_sh;  // shift amount comes from rs
    logic      sgn;     // signed multiply/divide
  } alu_dec_t;

  // Map aluop/funct to ALU control
  function automatic alu_dec_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    alu_dec_t d;
    d.ctrl   = ALU_ILL;
    d.ovf_en = 1'b0;
    d.var_sh = 1'b0;
    d.sgn    = 1'b0;
    case (aluop)
      ALUOP_ADD: begin d.ctrl = ALU_ADD; d.ovf_en = 1'b1; end
      ALUOP_SUB: begin d.ctrl = ALU_SUB; d.ovf_en = 1'b1; end
      ALUOP_OR:  d.ctrl = ALU_OR;
      default: begin
        case (funct)
          F_ADD:   begin d.ctrl = ALU_ADD; d.ovf_en = 1'b1; end
          F_ADDU:  d.ctrl = ALU_ADD;
          F_SUB:   begin d.ctrl = ALU_SUB; d.ovf_en = 1'b1; end
          F_SUBU:  d.ctrl = ALU_SUB;
          F_AND:   d.ctrl = ALU_AND;
          F_OR:    d.ctrl = ALU_OR;
          F_XOR:   d.ctrl = ALU_XOR;
          F_NOR:   d.ctrl = ALU_NOR;
          F_SLT:   d.ctrl = ALU_SLT;
          F_SLTU:  d.ctrl = ALU_SLTU;
          F_SLL:   d.ctrl = ALU_SLL;
          F_SRL:   d.ctrl = ALU_SRL;
          F_SRA:   d.ctrl = ALU_SRA;
          F_SLLV:  begin d.ctrl = ALU_SLL; d.var_sh = 1'b1; end
          F_SRLV:  begin d.ctrl = ALU_SRL; d.var_sh = 1'b1; end
          F_SRAV:  begin d.ctrl = ALU_SRA; d.var_sh = 1'b1; end
          F_MFHI:  d.ctrl = ALU_MFHI;
          F_MFLO:  d.ctrl = ALU_MFLO;
          F_MULT:  begin d.ctrl = ALU_MUL; d.sgn = 1'b1; end
          F_MULTU: d.ctrl = ALU_MUL;
          F_DIV:   begin d.ctrl = ALU_DIV; d.sgn = 1'b1; end
          F_DIVU:  d.ctrl = ALU_DIV;
          default: d.ctrl = ALU_ILL;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit owning HI/LO. One operand bit per cycle on
// magnitudes, then a fixup cycle applies signs and commits HI/LO.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_done_c,
  output logic [WIDTH-1:0] o_lo_next_c,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned SHW = $clog2(WIDTH);

  md_state_t        r_state;
  logic [SHW-1:0]   r_cnt;
  logic             r_ready;
  logic             r_is_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [WIDTH-1:0] r_a_orig;
  logic [WIDTH-1:0] r_opd;
  logic [WIDTH-1:0] r_p_hi;
  logic [WIDTH-1:0] r_p_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_dshift;
  logic [WIDTH:0]     w_dtrial;
  logic               w_dge;
  logic [WIDTH-1:0]   w_step_hi;
  logic [WIDTH-1:0]   w_step_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  // Operand magnitudes for signed ops
  always_comb begin
    w_mag_a = (i_signed && i_a[WIDTH-1]) ? (~i_a + WIDTH'(1)) : i_a;
    w_mag_b = (i_signed && i_b[WIDTH-1]) ? (~i_b + WIDTH'(1)) : i_b;
  end

  // One shift-add multiply or restoring divide step
  always_comb begin
    w_madd   = {1'b0, r_p_hi} + (r_p_lo[0] ? {1'b0, r_opd} : '0);
    w_dshift = {r_p_hi, r_p_lo[WIDTH-1]};
    w_dtrial = w_dshift - {1'b0, r_opd};
    w_dge    = (w_dshift >= {1'b0, r_opd});
    if (r_is_div) begin
      w_step_hi = w_dge ? w_dtrial[WIDTH-1:0] : w_dshift[WIDTH-1:0];
      w_step_lo = {r_p_lo[WIDTH-2:0], w_dge};
    end else begin
      w_step_hi = w_madd[WIDTH:1];
      w_step_lo = {w_madd[0], r_p_lo[WIDTH-1:1]};
    end
  end

  // Sign fixup and divide-by-zero override
  always_comb begin
    w_prod = {r_p_hi, r_p_lo};
    if (r_neg_q) w_prod = ~w_prod + (2*WIDTH)'(1);
    if (!r_is_div) begin
      w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_prod[WIDTH-1:0];
    end else if (r_dz) begin
      w_fix_hi = r_a_orig;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = r_neg_r ? (~r_p_hi + WIDTH'(1)) : r_p_hi;
      w_fix_lo = r_neg_q ? (~r_p_lo + WIDTH'(1)) : r_p_lo;
    end
  end

  // Sequencer: IDLE -> BUSY (WIDTH steps) -> FIXUP -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MD_IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_a_orig <= '0;
      r_opd    <= '0;
      r_p_hi   <= '0;
      r_p_lo   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_state  <= MD_BUSY;
            r_ready  <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= i_is_div;
            r_neg_q  <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r  <= i_signed & i_a[WIDTH-1];
            r_dz     <= i_is_div & (i_b == '0);
            r_a_orig <= i_a;
            r_opd    <= w_mag_b;
            r_p_hi   <= '0;
            r_p_lo   <= w_mag_a;
          end
        end
        MD_BUSY: begin
          r_p_hi <= w_step_hi;
          r_p_lo <= w_step_lo;
          r_cnt  <= r_cnt + SHW'(1);
          if (r_cnt == SHW'(WIDTH - 1)) r_state <= MD_FIXUP;
        end
        MD_FIXUP: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_ready <= 1'b1;
          r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_done_c    = (r_state == MD_FIXUP);
  assign o_lo_next_c = w_fix_lo;
  assign o_hi        = r_hi;
  assign o_lo        = r_lo;

endmodule

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU: aluop/funct decode, single-cycle integer ops
// and (with ALU_MULDIV_EN defined) iterative multiply/divide into HI/LO.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  alu_dec_t         w_dec;
  logic             w_accept;
  logic             w_is_md;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_lo_next;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;

  logic             r_valid_out;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic             r_illegal;

  // Decode; multiply/divide and HI/LO moves are illegal without the datapath
  always_comb begin
    w_dec = alu_decode(aluop, funct);
`ifndef ALU_MULDIV_EN
    if (w_dec.ctrl inside {ALU_MFHI, ALU_MFLO, ALU_MUL, ALU_DIV}) w_dec.ctrl = ALU_ILL;
`endif
  end

  assign w_accept = valid_in && ready_in;
  assign w_sh     = w_dec.var_sh ? a[SHW-1:0] : SHW'(shamt);

`ifdef ALU_MULDIV_EN
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_is_md = (w_dec.ctrl == ALU_MUL) || (w_dec.ctrl == ALU_DIV);

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (w_accept && w_is_md),
    .i_is_div    (w_dec.ctrl == ALU_DIV),
    .i_signed    (w_dec.sgn),
    .i_a         (a),
    .i_b         (b),
    .o_ready     (ready_in),
    .o_done_c    (w_md_done),
    .o_lo_next_c (w_md_lo_next),
    .o_hi        (w_hi),
    .o_lo        (w_lo)
  );
`else
  logic w_unused;

  assign w_is_md      = 1'b0;
  assign w_md_done    = 1'b0;
  assign w_md_lo_next = '0;
  assign ready_in     = 1'b1;
  assign w_unused     = w_dec.sgn;
`endif

  // Single-cycle ALU
  always_comb begin
    w_sum  = a + b;
    w_diff = a - b;
    w_res  = '0;
    w_ovf  = 1'b0;
    w_ill  = 1'b0;
    case (w_dec.ctrl)
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = w_dec.ovf_en & (a[WIDTH-1] == b[WIDTH-1]) & (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = w_dec.ovf_en & (a[WIDTH-1] != b[WIDTH-1]) & (w_diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  w_res = a & b;
      ALU_OR:   w_res = a | b;
      ALU_XOR:  w_res = a ^ b;
      ALU_NOR:  w_res = ~(a | b);
      ALU_SLT:  w_res = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: w_res = WIDTH'(a < b);
      ALU_SLL:  w_res = b << w_sh;
      ALU_SRL:  w_res = b >> w_sh;
      ALU_SRA:  w_res = $signed(b) >>> w_sh;
`ifdef ALU_MULDIV_EN
      ALU_MFHI: w_res = w_hi;
      ALU_MFLO: w_res = w_lo;
      ALU_MUL:  w_res = '0;
      ALU_DIV:  w_res = '0;
`endif
      default:  w_ill = 1'b1;
    endcase
  end

  // Output registers: muldiv completion or accepted single-cycle op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_out <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      if (w_md_done) begin
        r_valid_out <= 1'b1;
        r_result    <= w_md_lo_next;
        r_zero      <= 1'b0;
        r_overflow  <= 1'b0;
        r_illegal   <= 1'b0;
      end else if (w_accept && !w_is_md) begin
        r_valid_out <= 1'b1;
        r_result    <= w_res;
        r_zero      <= (w_res == '0);
        r_overflow  <= w_ovf;
        r_illegal   <= w_ill;
      end
    end
  end

  assign valid_out = r_valid_out;
  assign result    = r_result;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

endmodule
